// File: rtl/gf233_pkg.sv
// Shared constants, FSM state type and the Karatsuba recombine for GF(2^233) multiplication.
package gf233_pkg;

    localparam int M       = 233;         // field degree
    localparam int HALF_LO = 116;         // width of the low operand half
    localparam int HALF_HI = 117;         // width of the high operand half
    localparam int RED_K   = 74;          // middle term of f(x) = x^233 + x^74 + 1
    localparam int ZW      = 2 * HALF_HI; // partial product width from the shared multiplier
    localparam int PW      = 2 * M - 1;   // raw product width

    typedef enum logic [2:0] {
        StIdle,
        StIss0,
        StIss1,
        StIss2,
        StWait,
        StRed,
        StDone
    } state_e;

    // p = z2*x^232 + (z0+z1+z2)*x^116 + z0, carry-free
    function automatic logic [PW-1:0] karatsuba_recombine(input logic [ZW-1:0] z0,
                                                         input logic [ZW-1:0] z1,
                                                         input logic [ZW-1:0] z2);
        logic [PW-1:0] e0;
        logic [PW-1:0] e1;
        logic [PW-1:0] e2;
        e0 = {{(PW-ZW){1'b0}}, z0};
        e1 = {{(PW-ZW){1'b0}}, z0 ^ z1 ^ z2} << HALF_LO;
        e2 = {{(PW-ZW){1'b0}}, z2} << (2 * HALF_LO);
        return e0 ^ e1 ^ e2;
    endfunction

endpackage

// File: rtl/gf233_reduce.sv
// Combinational reduction of a 465-bit raw product modulo x^233 + x^74 + 1 (two folds).
module gf233_reduce
    import gf233_pkg::*;
(
    input  logic [PW-1:0] p,
    output logic [M-1:0]  r
);

    localparam int HIW = PW - M;      // bits above x^232 in the raw product
    localparam int F1W = HIW + RED_K; // first fold can reach degree 305
    localparam int H2W = F1W - M;     // bits left above x^232 after the first fold

    logic [HIW-1:0] hi1;
    logic [F1W-1:0] f1;
    logic [H2W-1:0] hi2;

    // Fold each term above x^232 back using x^233 = x^74 + 1
    always_comb begin
        hi1 = p[PW-1:M];
        f1  = {{(F1W-M){1'b0}}, p[M-1:0]}
            ^ {{(F1W-HIW){1'b0}}, hi1}
            ^ {hi1, {RED_K{1'b0}}};
        hi2 = f1[F1W-1:M];
        r   = f1[M-1:0]
            ^ {{(M-H2W){1'b0}}, hi2}
            ^ {{(M-H2W-RED_K){1'b0}}, hi2, {RED_K{1'b0}}};
    end

endmodule

// File: rtl/gf233_mul_ctrl.sv
// Sequencer for GF(2^233) multiplication: three Karatsuba passes through a shared
// 117x117 carry-less multiplier, recombine, reduce, and hand off over valid/ready.
module gf233_mul_ctrl
    import gf233_pkg::*;
#(
    parameter int unsigned MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     a,
    input  logic [M-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     c,
    output logic             mul_en,
    output logic [HALF_HI-1:0] mul_a,
    output logic [HALF_HI-1:0] mul_b,
    input  logic [ZW-1:0]    mul_d
);

    // Counter values (cycles since the z0 issue) at which each product is on mul_d
    localparam logic [3:0] CAP0 = 4'(MULT_LAT);
    localparam logic [3:0] CAP1 = 4'(MULT_LAT + 1);
    localparam logic [3:0] CAP2 = 4'(MULT_LAT + 2);

    state_e             state_q, state_d;
    logic               accept;
    logic               in_flight;
    logic [M-1:0]       a_q, b_q;
    logic [M-1:0]       src_a, src_b;
    logic [3:0]         cnt_q;
    logic [ZW-1:0]      z0_q, z1_q, z2_q;
    logic               mul_en_q, mul_en_d;
    logic [HALF_HI-1:0] mul_a_q, mul_a_d;
    logic [HALF_HI-1:0] mul_b_q, mul_b_d;
    logic [M-1:0]       c_q;
    logic               out_valid_q;
    logic [PW-1:0]      p;
    logic [M-1:0]       r;

    assign in_flight = (state_q == StIss0) || (state_q == StIss1) ||
                       (state_q == StIss2) || (state_q == StWait);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = StIss0;
                end
            end
            StIss0: state_d = StIss1;
            StIss1: state_d = StIss2;
            StIss2: state_d = StWait;
            StWait: if (cnt_q == CAP2) state_d = StRed;
            StRed:  state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Multiplier operands for the state being entered; operands are not yet latched on accept
    always_comb begin
        src_a    = (state_q == StIdle) ? a : a_q;
        src_b    = (state_q == StIdle) ? b : b_q;
        mul_en_d = 1'b0;
        mul_a_d  = '0;
        mul_b_d  = '0;
        unique case (state_d)
            StIss0: begin
                mul_en_d = 1'b1;
                mul_a_d  = {1'b0, src_a[HALF_LO-1:0]};
                mul_b_d  = {1'b0, src_b[HALF_LO-1:0]};
            end
            StIss1: begin
                mul_en_d = 1'b1;
                mul_a_d  = {1'b0, src_a[HALF_LO-1:0]} ^ src_a[M-1:HALF_LO];
                mul_b_d  = {1'b0, src_b[HALF_LO-1:0]} ^ src_b[M-1:HALF_LO];
            end
            StIss2: begin
                mul_en_d = 1'b1;
                mul_a_d  = src_a[M-1:HALF_LO];
                mul_b_d  = src_b[M-1:HALF_LO];
            end
            default: ;
        endcase
    end

    // State register, operand latches and issue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (accept) begin
                cnt_q <= '0;
            end else if (in_flight) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Capture each partial product exactly MULT_LAT cycles after its issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z0_q <= '0;
            z1_q <= '0;
            z2_q <= '0;
        end else if (in_flight) begin
            if (cnt_q == CAP0) z0_q <= mul_d;
            if (cnt_q == CAP1) z1_q <= mul_d;
            if (cnt_q == CAP2) z2_q <= mul_d;
        end
    end

    // Registered multiplier interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_en_q <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            mul_en_q <= mul_en_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    assign p = karatsuba_recombine(z0_q, z1_q, z2_q);

    gf233_reduce u_reduce (
        .p (p),
        .r (r)
    );

    // Result register and valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (state_q == StRed) c_q <= r;
            out_valid_q <= (state_d == StDone);
        end
    end

    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_gf233_mul_ctrl.sv
// Scoreboard bench: two controllers (MULT_LAT 1 and 4) share stimulus, each driving its
// own behavioural multiplier; results are checked against a shift-and-add GF(2^233) model.
module tb_gf233_mul_ctrl;

    localparam int LAT0  = 1;
    localparam int LAT1  = 4;
    localparam int NRAND = 1500;
    localparam logic [233:0] FPOLY = (234'd1 << 233) | (234'd1 << 74) | 234'd1;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [232:0] a, b;

    logic         in_ready  [2];
    logic         out_valid [2];
    logic         mul_en    [2];
    logic [232:0] c         [2];
    logic [116:0] mul_a     [2];
    logic [116:0] mul_b     [2];
    logic [233:0] mul_d     [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [232:0] exp_q0 [$];
    logic [232:0] exp_q1 [$];
    logic         busy    [2];
    logic         ov_prev [2];
    int           acc_cyc [2];
    int           iss_cnt [2];
    logic [232:0] cur_a   [2];
    logic [232:0] cur_b   [2];
    logic [232:0] c_hold  [2];

    always #5 clk = ~clk;

    gf233_mul_ctrl #(.MULT_LAT(LAT0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready[0]),
        .a         (a),
        .b         (b),
        .out_valid (out_valid[0]),
        .out_ready (out_ready),
        .c         (c[0]),
        .mul_en    (mul_en[0]),
        .mul_a     (mul_a[0]),
        .mul_b     (mul_b[0]),
        .mul_d     (mul_d[0])
    );

    gf233_mul_ctrl #(.MULT_LAT(LAT1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready[1]),
        .a         (a),
        .b         (b),
        .out_valid (out_valid[1]),
        .out_ready (out_ready),
        .c         (c[1]),
        .mul_en    (mul_en[1]),
        .mul_a     (mul_a[1]),
        .mul_b     (mul_b[1]),
        .mul_d     (mul_d[1])
    );

    function automatic logic [233:0] rnd234();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[233:0];
    endfunction

    function automatic logic [232:0] rnd233();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[232:0];
    endfunction

    // Plain carry-less product
    function automatic logic [233:0] clmul(input logic [116:0] x, input logic [116:0] y);
        logic [233:0] acc;
        acc = '0;
        for (int i = 0; i < 117; i++) begin
            if (y[i]) acc = acc ^ ({117'b0, x} << i);
        end
        return acc;
    endfunction

    // Interleaved shift-and-add multiply with reduction mod f(x)
    function automatic logic [232:0] gf_mul(input logic [232:0] x, input logic [232:0] y);
        logic [233:0] sh;
        logic [232:0] acc;
        sh  = {1'b0, x};
        acc = '0;
        for (int i = 0; i < 233; i++) begin
            if (y[i]) acc = acc ^ sh[232:0];
            sh = sh << 1;
            if (sh[233]) sh = sh ^ FPOLY;
        end
        return acc;
    endfunction

    function automatic logic [116:0] exp_op(input logic [232:0] x, input int j);
        logic [116:0] lo;
        logic [116:0] hi;
        lo = {1'b0, x[115:0]};
        hi = x[232:116];
        case (j)
            0:       return lo;
            1:       return lo ^ hi;
            default: return hi;
        endcase
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // Behavioural shared multipliers; garbage on mul_d whenever no real operation is in flight
    for (genvar k = 0; k < 2; k++) begin : g_mul
        localparam int L = (k == 0) ? LAT0 : LAT1;
        logic [233:0] pipe [L];
        always @(posedge clk) begin
            pipe[0] <= mul_en[k] ? clmul(mul_a[k], mul_b[k]) : rnd234();
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mul_d[k] = pipe[L-1];
    end

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or no expected value", name);
    endtask

    task automatic chkv(input string name, input int k, input logic [233:0] act,
                        input logic [233:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic chki(input string name, input int k, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic sb_push(input int k, input logic [232:0] v);
        if (k == 0) exp_q0.push_back(v);
        else        exp_q1.push_back(v);
    endtask

    task automatic sb_pop(input int k, output logic [232:0] v, output logic ok);
        ok = 1'b0;
        v  = '0;
        if (k == 0 && exp_q0.size() > 0) begin
            v  = exp_q0.pop_front();
            ok = 1'b1;
        end else if (k == 1 && exp_q1.size() > 0) begin
            v  = exp_q1.pop_front();
            ok = 1'b1;
        end
    endtask

    // One negedge of monitoring for both instances
    task automatic monitor_step();
        logic [232:0] e;
        logic         ok;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if (k == 0) exp_q0.delete();
                else        exp_q1.delete();
                busy[k]    = 1'b0;
                ov_prev[k] = 1'b0;
                iss_cnt[k] = 0;
                chkv("rst_in_ready",  k, 234'(in_ready[k]),  234'd0);
                chkv("rst_out_valid", k, 234'(out_valid[k]), 234'd0);
                chkv("rst_mul_en",    k, 234'(mul_en[k]),    234'd0);
                chkv("rst_c",         k, 234'(c[k]),         234'd0);
                chkv("rst_mul_ab",    k, 234'({mul_a[k], mul_b[k]}), 234'd0);
            end else begin
                chkv("in_ready", k, 234'(in_ready[k]), 234'(!busy[k]));
                if (mul_en[k]) begin
                    chki("issue_cycle", k, cyc - acc_cyc[k], iss_cnt[k] + 1);
                    if (iss_cnt[k] < 3) begin
                        chkv("mul_a", k, 234'(mul_a[k]), 234'(exp_op(cur_a[k], iss_cnt[k])));
                        chkv("mul_b", k, 234'(mul_b[k]), 234'(exp_op(cur_b[k], iss_cnt[k])));
                    end
                    iss_cnt[k]++;
                end else begin
                    chkv("mul_idle_zero", k, 234'({mul_a[k], mul_b[k]}), 234'd0);
                end
                if (out_valid[k] && !ov_prev[k]) begin
                    chki("latency", k, cyc - acc_cyc[k], 5 + lat_of(k));
                    c_hold[k] = c[k];
                end else if (out_valid[k]) begin
                    chkv("c_stable", k, 234'(c[k]), 234'(c_hold[k]));
                end
                if (out_valid[k] && out_ready) begin
                    sb_pop(k, e, ok);
                    if (!ok) fail_now("unexpected_result");
                    else     chkv("c", k, 234'(c[k]), 234'(e));
                    chki("issue_count", k, iss_cnt[k], 3);
                    busy[k] = 1'b0;
                end
                if (in_valid && in_ready[k]) begin
                    sb_push(k, gf_mul(a, b));
                    busy[k]    = 1'b1;
                    acc_cyc[k] = cyc;
                    iss_cnt[k] = 0;
                    cur_a[k]   = a;
                    cur_b[k]   = b;
                end
                ov_prev[k] = out_valid[k];
            end
        end
    endtask

    // Present one operation once both controllers are idle, so both accept on the same edge
    task automatic issue(input logic [232:0] ia, input logic [232:0] ib);
        int t;
        t = 0;
        while (!(in_ready[0] && in_ready[1]) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            fail_now("issue_timeout");
        end else begin
            a        = ia;
            b        = ib;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(exp_q0.size() == 0 && exp_q1.size() == 0 && in_ready[0] && in_ready[1])
               && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) fail_now("drain_timeout");
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        fork
            forever monitor_step();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed: identity, single x^233 fold, double fold
        issue(233'd1, 233'd1);
        drain();
        issue(233'd1 << 232, 233'd2);
        drain();
        issue(233'd1 << 232, 233'd1 << 232);
        drain();

        // Back-pressure with new operands held on the input throughout
        out_ready = 1'b0;
        issue(rnd233(), rnd233());
        a        = rnd233();
        b        = rnd233();
        in_valid = 1'b1;
        t = 0;
        while (!(out_valid[0] && out_valid[1]) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) fail_now("out_valid_timeout");
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset while waiting on the multiplier, then a clean operation
        issue(rnd233(), rnd233());
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(233'd3, 233'd5);
        drain();

        // Randomised operations with occasional dense operands
        for (int i = 0; i < NRAND; i++) begin
            logic [232:0] ra;
            logic [232:0] rb;
            ra = ($urandom_range(7) == 0) ? '1 : rnd233();
            rb = ($urandom_range(7) == 0) ? '1 : rnd233();
            issue(ra, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
